uart_rx_keys: RTL and testbench

//  Parametrised UART receiver for the Bluetooth module link; successor to the fixed 9600-baud, 8N1 key receiver.

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_fifo.sv | 47 ++++
 rtl/uart_rx_keys.sv | 171 +++++++++++++++++
 tb/tb_uart_rx_keys.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART key receiver.
// Receiver FSM states and parity mode encodings.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

endpackage

// File: rtl/sync_fifo.sv
// Byte FIFO with first-word-fall-through read.
// Pointers carry an extra wrap bit to tell full from empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp;
  logic [AW:0]      rp;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) &&
                   (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot a full push needs
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx_keys.sv
// UART receiver with byte FIFO and one-hot key decoder
// for the Bluetooth piano link.
module uart_rx_keys
  import uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 10417,
  parameter int          DATA_BITS    = 8,
  parameter int          PARITY       = 0,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [7:0]  KEY_BASE     = 8'h41,
  parameter int          NUM_KEYS     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [NUM_KEYS-1:0]  key_onehot,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] HALF = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] FULL = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);
  localparam logic [NUM_KEYS-1:0] ONE = NUM_KEYS'(1);

  state_t               state;
  logic                 s1;
  logic                 line;
  logic                 line_prev;
  logic [BW-1:0]        baud_cnt;
  logic [CW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] rx_byte;
  logic                 par_bad;
  logic                 push;
  logic                 full;
  logic                 empty;
  logic [31:0]          bval;
  logic [31:0]          kbase;
  logic                 in_range;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= 1'b1;
      line      <= 1'b1;
      line_prev <= 1'b1;
    end else begin
      s1        <= rxd;
      line      <= s1;
      line_prev <= line;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      rx_byte    <= '0;
      par_bad    <= 1'b0;
      push       <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      push       <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (line_prev && !line) begin
            state    <= ST_START;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            par_bad  <= 1'b0;
          end
        end
        ST_START: begin
          if (baud_cnt == HALF) begin
            baud_cnt <= '0;
            state    <= line ? ST_IDLE : ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_cnt == FULL) begin
            baud_cnt <= '0;
            // LSB first: after DATA_BITS shifts bit 0 holds the first sample
            shreg    <= {line, shreg[DATA_BITS-1:1]};
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == LAST)
              state <= (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (baud_cnt == FULL) begin
            baud_cnt <= '0;
            par_bad  <= (^shreg) ^ line ^ (PARITY == PARITY_ODD);
            state    <= ST_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (baud_cnt == FULL) begin
            baud_cnt <= '0;
            if (!line) begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end else if (par_bad) begin
              parity_err <= 1'b1;
              state      <= ST_IDLE;
            end else begin
              push    <= 1'b1;
              rx_byte <= shreg;
              state   <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_BREAK: begin
          if (line) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bval     = 32'(rx_byte);
  assign kbase    = 32'(KEY_BASE);
  assign in_range = (bval >= kbase) &&
                    (bval < kbase + 32'(NUM_KEYS));

  always_ff @(posedge clk) begin
    if (rst) begin
      key_onehot <= '0;
      overrun    <= 1'b0;
    end else begin
      overrun <= push && full && !m_ready;
      if (push && in_range)
        key_onehot <= ONE << (bval - kbase);
    end
  end

  sync_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (rx_byte),
    .full (full),
    .pop  (m_ready),
    .dout (m_data),
    .empty(empty)
  );

  assign m_valid = !empty;

endmodule

// File: tb/tb_uart_rx_keys.sv
// Directed bench for uart_rx_keys: an 8N1 instance (a)
// and an 8E1 instance (b) sharing clock and reset.
module tb_uart_rx_keys;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_rxd = 1'b1;
  logic       b_rxd = 1'b1;
  logic       a_ready = 1'b0;
  logic       b_ready = 1'b0;
  logic [7:0] a_data;
  logic [7:0] b_data;
  logic       a_valid;
  logic       b_valid;
  logic [3:0] a_key;
  logic [3:0] b_key;
  logic       a_perr, a_ferr, a_ovr;
  logic       b_perr, b_ferr, b_ovr;

  int tests = 0;
  int fails = 0;
  int a_perr_n = 0, a_ferr_n = 0, a_ovr_n = 0;
  int b_perr_n = 0, b_ferr_n = 0, b_ovr_n = 0;
  logic [7:0] a_q [$];
  logic [7:0] b_q [$];

  always #5 clk = ~clk;

  uart_rx_keys #(
    .CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0),
    .FIFO_DEPTH(8), .KEY_BASE(8'h41), .NUM_KEYS(4)
  ) dut_a (
    .clk(clk), .rst(rst), .rxd(a_rxd),
    .m_data(a_data), .m_valid(a_valid), .m_ready(a_ready),
    .key_onehot(a_key), .parity_err(a_perr),
    .frame_err(a_ferr), .overrun(a_ovr)
  );

  uart_rx_keys #(
    .CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2),
    .FIFO_DEPTH(8), .KEY_BASE(8'h41), .NUM_KEYS(4)
  ) dut_b (
    .clk(clk), .rst(rst), .rxd(b_rxd),
    .m_data(b_data), .m_valid(b_valid), .m_ready(b_ready),
    .key_onehot(b_key), .parity_err(b_perr),
    .frame_err(b_ferr), .overrun(b_ovr)
  );

  always @(posedge clk) begin
    if (!rst) begin
      if (a_valid && a_ready) a_q.push_back(a_data);
      if (b_valid && b_ready) b_q.push_back(b_data);
      if (a_perr) a_perr_n++;
      if (a_ferr) a_ferr_n++;
      if (a_ovr)  a_ovr_n++;
      if (b_perr) b_perr_n++;
      if (b_ferr) b_ferr_n++;
      if (b_ovr)  b_ovr_n++;
    end
  end

  task automatic drive(input bit sel, input logic v);
    if (sel) b_rxd = v;
    else     a_rxd = v;
  endtask

  task automatic send_bit(input bit sel, input logic v);
    drive(sel, v);
    repeat (16) @(negedge clk);
  endtask

  task automatic send(input bit sel, input logic [7:0] d,
                      input bit has_par, input logic par,
                      input logic stop);
    send_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
    if (has_par) send_bit(sel, par);
    send_bit(sel, stop);
    if (stop) repeat (32) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    tests++;
    if ({a_valid, a_data, a_key, a_perr, a_ferr, a_ovr} !== 16'h0) begin
      fails++;
      $display("FAIL reset_a: got valid=%b data=%h key=%b p=%b f=%b o=%b want all 0",
               a_valid, a_data, a_key, a_perr, a_ferr, a_ovr);
    end
    tests++;
    if ({b_valid, b_data, b_key, b_perr, b_ferr, b_ovr} !== 16'h0) begin
      fails++;
      $display("FAIL reset_b: got valid=%b data=%h key=%b want all 0",
               b_valid, b_data, b_key);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_8n1_keys;
    logic [3:0] exp_key [4];
    exp_key[0] = 4'b0001; exp_key[1] = 4'b0010;
    exp_key[2] = 4'b0100; exp_key[3] = 4'b1000;
    a_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 8'h41 + 8'(i), 1'b0, 1'b0, 1'b1);
      tests++;
      if (a_key !== exp_key[i]) begin
        fails++;
        $display("FAIL key_%0d: got %b want %b", i, a_key, exp_key[i]);
      end
    end
    tests++;
    if (a_q.size() != 4) begin
      fails++;
      $display("FAIL pop_count: got %0d want 4", a_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (a_q[i] !== 8'h41 + 8'(i)) begin
          fails++;
          $display("FAIL pop_%0d: got %h want %h", i, a_q[i], 8'h41 + 8'(i));
        end
      end
    end
    tests++;
    if (a_perr_n + a_ferr_n + a_ovr_n != 0) begin
      fails++;
      $display("FAIL no_err_8n1: got %0d pulses want 0",
               a_perr_n + a_ferr_n + a_ovr_n);
    end
  endtask

  task automatic test_glitch;
    drive(1'b0, 1'b0);
    repeat (5) @(negedge clk);
    drive(1'b0, 1'b1);
    repeat (40) @(negedge clk);
    tests++;
    if (a_q.size() != 4 || a_perr_n + a_ferr_n != 0) begin
      fails++;
      $display("FAIL glitch: got pops=%0d errs=%0d want 4 0",
               a_q.size(), a_perr_n + a_ferr_n);
    end
    send(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
    tests++;
    if (a_q.size() != 5 || a_q[a_q.size()-1] !== 8'h55) begin
      fails++;
      $display("FAIL after_glitch: got pops=%0d want 5 with last 55", a_q.size());
    end
    tests++;
    if (a_key !== 4'b1000) begin
      fails++;
      $display("FAIL key_hold: got %b want 1000", a_key);
    end
  endtask

  task automatic test_parity;
    b_ready = 1'b1;
    send(1'b1, 8'h42, 1'b1, 1'b0, 1'b1);
    tests++;
    if (b_q.size() != 1 || b_key !== 4'b0010 || b_perr_n != 0) begin
      fails++;
      $display("FAIL even_good: got pops=%0d key=%b perr=%0d want 1 0010 0",
               b_q.size(), b_key, b_perr_n);
    end
    send(1'b1, 8'h41, 1'b1, 1'b1, 1'b1);
    tests++;
    if (b_perr_n != 1) begin
      fails++;
      $display("FAIL parity_err: got %0d pulse cycles want 1", b_perr_n);
    end
    tests++;
    if (b_q.size() != 1 || b_key !== 4'b0010 || b_ferr_n != 0) begin
      fails++;
      $display("FAIL parity_drop: got pops=%0d key=%b ferr=%0d want 1 0010 0",
               b_q.size(), b_key, b_ferr_n);
    end
  endtask

  task automatic test_frame_err;
    send(1'b0, 8'h42, 1'b0, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    tests++;
    if (a_ferr_n != 1 || a_perr_n != 0) begin
      fails++;
      $display("FAIL frame_err: got ferr=%0d perr=%0d want 1 0", a_ferr_n, a_perr_n);
    end
    tests++;
    if (a_q.size() != 5 || a_key !== 4'b1000) begin
      fails++;
      $display("FAIL break_hold: got pops=%0d key=%b want 5 1000", a_q.size(), a_key);
    end
    drive(1'b0, 1'b1);
    repeat (32) @(negedge clk);
    send(1'b0, 8'h43, 1'b0, 1'b0, 1'b1);
    tests++;
    if (a_q.size() != 6 || a_q[a_q.size()-1] !== 8'h43 || a_key !== 4'b0100) begin
      fails++;
      $display("FAIL after_break: got pops=%0d key=%b want 6 0100", a_q.size(), a_key);
    end
  endtask

  task automatic test_overrun;
    a_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(1'b0, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b1);
    send(1'b0, 8'h41, 1'b0, 1'b0, 1'b1);
    tests++;
    if (a_ovr_n != 1) begin
      fails++;
      $display("FAIL overrun: got %0d want 1", a_ovr_n);
    end
    tests++;
    if (a_valid !== 1'b1 || a_data !== 8'h10 || a_key !== 4'b0001) begin
      fails++;
      $display("FAIL full_head: got valid=%b data=%h key=%b want 1 10 0001",
               a_valid, a_data, a_key);
    end
    a_q.delete();
    a_ready = 1'b1;
    repeat (8) @(negedge clk);
    a_ready = 1'b0;
    tests++;
    if (a_q.size() != 8 || a_valid !== 1'b0) begin
      fails++;
      $display("FAIL drain: got pops=%0d valid=%b want 8 0", a_q.size(), a_valid);
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests++;
        if (a_q[i] !== 8'h10 + 8'(i)) begin
          fails++;
          $display("FAIL drain_%0d: got %h want %h", i, a_q[i], 8'h10 + 8'(i));
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] d;
    d = 8'h43;
    send(1'b0, 8'h20, 1'b0, 1'b0, 1'b1);
    tests++;
    if (a_valid !== 1'b1 || a_data !== 8'h20) begin
      fails++;
      $display("FAIL pre_rst: got valid=%b data=%h want 1 20", a_valid, a_data);
    end
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0, d[i]);
    rst = 1'b1;
    a_rxd = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({a_valid, a_data, a_key, a_perr, a_ferr, a_ovr} !== 16'h0 || b_key !== 4'h0) begin
      fails++;
      $display("FAIL mid_rst: got valid=%b data=%h key=%b bkey=%b want all 0",
               a_valid, a_data, a_key, b_key);
    end
    rst = 1'b0;
    repeat (200) @(negedge clk);
    tests++;
    if (a_ferr_n != 1 || a_perr_n != 0 || a_ovr_n != 1 || a_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_quiet: got ferr=%0d perr=%0d ovr=%0d valid=%b want 1 0 1 0",
               a_ferr_n, a_perr_n, a_ovr_n, a_valid);
    end
    send(1'b0, 8'h44, 1'b0, 1'b0, 1'b1);
    tests++;
    if (a_key !== 4'b1000 || a_valid !== 1'b1 || a_data !== 8'h44) begin
      fails++;
      $display("FAIL post_rst: got key=%b valid=%b data=%h want 1000 1 44",
               a_key, a_valid, a_data);
    end
  endtask

  initial begin
    test_reset;
    test_8n1_keys;
    test_glitch;
    test_parity;
    test_frame_err;
    test_overrun;
    test_reset_mid_frame;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
